// File: rtl/riscv_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// riscv_multicycle_ctrl_if
// Groups the instruction-register fields, the ALU zero flag and every control
// line exchanged between the multicycle control unit and the datapath.
//   master : the control unit (consumes op/funct/zero, drives all controls)
//   slave  : the datapath (drives op/funct/zero, consumes all controls)
// Signals:
//   op[6:0], funct3[2:0], funct7b5   instruction fields from the IR
//   zero                             ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite    enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc [1:0]       datapath mux selects
//   ALUControl[2:0]                  ALU operation code
//   illegal_instr                    unsupported-instruction pulse in Decode
//   state[STATE_W-1:0]               current FSM state, for debug
// ----------------------------------------------------------------------------
interface riscv_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ImmSrc;
    logic [2:0]         ALUControl;
    logic               RegWrite;
    logic               illegal_instr;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal_instr, state
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal_instr, state
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_multicycle_ctrl
// Multicycle RISC-V control unit: Moore FSM sequencing fetch / decode /
// execute / writeback plus a combinational ALU decoder. Only the state
// register is sequential; every output decodes from state, op, funct3,
// funct7b5 and zero.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (forces Fetch, masks all enables)
//   bus    riscv_multicycle_ctrl_if.master (IR fields in, controls out)
// ----------------------------------------------------------------------------
module riscv_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         STATE_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    riscv_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // ALU decoder: maps the FSM's ALU request plus funct fields to ALUControl.
    function automatic logic [2:0] alu_decode(
        input aluop_t     aluop,
        input logic [2:0] f3,
        input logic       op5,
        input logic       f7b5
    );
        logic [2:0] code;
        code = 3'b000;
        case (aluop)
            ALUOP_ADD: code = 3'b000;
            ALUOP_SUB: code = 3'b001;
            ALUOP_FUNCT: begin
                case (f3)
                    3'b000:  code = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  code = 3'b101;
                    3'b110:  code = 3'b011;
                    3'b111:  code = 3'b010;
                    default: code = 3'b000;
                endcase
            end
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    state_t     r_state;
    state_t     w_next_state;
    aluop_t     w_aluop;
    logic       w_pcwrite;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_immsrc;
    logic       w_op_legal;
    logic       w_f3_legal;
    logic       w_op_is_alu;

    // State register; reset aborts any in-flight instruction back to Fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode / funct3 legality used by Decode for the illegal_instr pulse.
    always_comb begin
        w_op_legal  = 1'b0;
        w_f3_legal  = 1'b0;
        w_op_is_alu = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_JAL, OP_BEQ: w_op_legal = 1'b1;
            OP_R, OP_I: begin
                w_op_legal  = 1'b1;
                w_op_is_alu = 1'b1;
            end
            default: w_op_legal = 1'b0;
        endcase
        case (bus.funct3)
            3'b000, 3'b010, 3'b110, 3'b111: w_f3_legal = 1'b1;
            default:                        w_f3_legal = 1'b0;
        endcase
    end

    // Immediate format depends only on the opcode, so it is valid in every state.
    always_comb begin
        w_immsrc = 2'b00;
        case (bus.op)
            OP_SW:   w_immsrc = 2'b01;
            OP_BEQ:  w_immsrc = 2'b10;
            OP_JAL:  w_immsrc = 2'b11;
            default: w_immsrc = 2'b00;
        endcase
    end

    // Next-state and Moore output decode; the reset mask is applied afterwards.
    always_comb begin
        w_next_state = S_FETCH;
        w_aluop      = ALUOP_ADD;
        w_pcwrite    = 1'b0;
        w_adrsrc     = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_illegal    = 1'b0;
        w_resultsrc  = 2'b00;
        w_alusrca    = 2'b00;
        w_alusrcb    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite    = 1'b1;
                w_alusrcb    = 2'b10;
                w_resultsrc  = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm as a potential branch target.
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                w_illegal = ~w_op_legal | (w_op_is_alu & ~w_f3_legal);
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 2'b10;
                w_alusrcb    = 2'b01;
                w_next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc     = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc  = 2'b01;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc     = 1'b1;
                w_memwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECR: begin
                w_alusrca    = 2'b10;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca    = 2'b10;
                w_alusrcb    = 2'b01;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_alusrca    = 2'b01;
                w_alusrcb    = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BEQ: begin
                // Branch taken writes the target computed in Decode (ALUOut).
                w_alusrca    = 2'b10;
                w_aluop      = ALUOP_SUB;
                w_pcwrite    = bus.zero;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Drive the interface; enables and illegal_instr are forced low during reset.
    always_comb begin
        bus.PCWrite       = w_pcwrite  & ~reset;
        bus.MemWrite      = w_memwrite & ~reset;
        bus.IRWrite       = w_irwrite  & ~reset;
        bus.RegWrite      = w_regwrite & ~reset;
        bus.illegal_instr = w_illegal  & ~reset;
        bus.AdrSrc        = w_adrsrc;
        bus.ResultSrc     = w_resultsrc;
        bus.ALUSrcA       = w_alusrca;
        bus.ALUSrcB       = w_alusrcb;
        bus.ImmSrc        = w_immsrc;
        bus.ALUControl    = alu_decode(w_aluop, bus.funct3, bus.op[5], bus.funct7b5);
        bus.state         = STATE_W'(r_state);
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_riscv_multicycle_ctrl
// Scoreboard bench: for each instruction the expected per-cycle outputs are
// built from a reference table of the control FSM and pushed to a queue when
// the instruction is applied; each cycle one entry is popped and compared
// against the DUT, sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_riscv_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] en;    // {PCWrite, MemWrite, IRWrite, RegWrite, illegal_instr}
        logic [8:0] mux;   // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc}
        logic [2:0] aluc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    riscv_multicycle_ctrl_if #(.STATE_W(4)) bus ();

    riscv_multicycle_ctrl #(
        .RESET_STATE (4'd0),
        .STATE_W     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference table of what the controller should present in a given state.
    function automatic exp_t model(input logic [3:0] st, input logic [6:0] op,
                                   input logic [2:0] f3, input logic f7, input logic z);
        exp_t e;
        logic [1:0] imm;
        logic       ill;
        logic [2:0] fcode;
        imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        fcode = (f3 == 3'b010) ? 3'b101 : (f3 == 3'b110) ? 3'b011 :
                (f3 == 3'b111) ? 3'b010 : (f3 == 3'b000 && op[5] && f7) ? 3'b001 : 3'b000;
        ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011) ||
              ((op == 7'b0110011 || op == 7'b0010011) &&
               !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111));
        e.st   = st;
        e.en   = 5'b00000;
        e.mux  = {1'b0, 2'b00, 2'b00, 2'b00, imm};
        e.aluc = 3'b000;
        case (st)
            4'd0:  begin e.en = 5'b10100; e.mux = {1'b0, 2'b10, 2'b00, 2'b10, imm}; end
            4'd1:  begin e.en = {4'b0000, ill}; e.mux = {1'b0, 2'b00, 2'b01, 2'b01, imm}; end
            4'd2:  e.mux = {1'b0, 2'b00, 2'b10, 2'b01, imm};
            4'd3:  e.mux = {1'b1, 2'b00, 2'b00, 2'b00, imm};
            4'd4:  begin e.en = 5'b00010; e.mux = {1'b0, 2'b01, 2'b00, 2'b00, imm}; end
            4'd5:  begin e.en = 5'b01000; e.mux = {1'b1, 2'b00, 2'b00, 2'b00, imm}; end
            4'd6:  begin e.mux = {1'b0, 2'b00, 2'b10, 2'b00, imm}; e.aluc = fcode; end
            4'd7:  begin e.mux = {1'b0, 2'b00, 2'b10, 2'b01, imm}; e.aluc = fcode; end
            4'd8:  e.en = 5'b00010;
            4'd9:  begin e.en = 5'b10000; e.mux = {1'b0, 2'b00, 2'b01, 2'b10, imm}; end
            4'd10: begin e.en = {z, 4'b0000}; e.mux = {1'b0, 2'b00, 2'b10, 2'b00, imm}; e.aluc = 3'b001; end
            default: e.en = 5'b00000;
        endcase
        return e;
    endfunction

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_val({tag, ".state"}, 32'(bus.state), 32'(e.st));
        check_val({tag, ".en"},    32'({bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.illegal_instr}), 32'(e.en));
        check_val({tag, ".mux"},   32'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc}), 32'(e.mux));
        check_val({tag, ".aluc"},  32'(bus.ALUControl), 32'(e.aluc));
    endtask

    // Applies one instruction from Fetch, checks every cycle, returns in Fetch.
    // n_steps limits how many path states are run (0 = whole path).
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int n_steps);
        int path[$];
        int n;
        case (op)
            7'b0000011: path = '{0, 1, 2, 3, 4};
            7'b0100011: path = '{0, 1, 2, 5};
            7'b0110011: path = '{0, 1, 6, 8};
            7'b0010011: path = '{0, 1, 7, 8};
            7'b1101111: path = '{0, 1, 9, 8};
            7'b1100011: path = '{0, 1, 10};
            default:    path = '{0, 1};
        endcase
        n = (n_steps == 0) ? path.size() : n_steps;
        for (int i = 0; i < n; i++) begin
            sb.push_back(model(4'(path[i]), op, f3, f7, z));
        end
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
        for (int i = 0; i < n; i++) begin
            #1;
            pop_compare(tag);
            if (i < n - 1 || n_steps == 0) begin
                @(posedge clk);
            end
        end
    endtask

    initial begin
        exp_t e;
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.op       = 7'b1111111;
        bus.funct3   = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;
        repeat (2) @(posedge clk);
        // Reset held: Fetch state with all enables masked.
        e = model(4'd0, 7'b1111111, 3'b000, 1'b0, 1'b0);
        e.en = 5'b00000;
        sb.push_back(e);
        #1;
        pop_compare("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        bus.op = 7'b0110011;
        #0;
        // Reset released at the previous negedge: DUT stepped Fetch -> Decode
        // on this edge only if reset was low, so re-align with one more reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("r_sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0);
        run_instr("r_add",  7'b0110011, 3'b000, 1'b0, 1'b0, 0);
        run_instr("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 0);
        run_instr("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 0);
        run_instr("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 0);
        run_instr("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 0);
        run_instr("i_slt",  7'b0010011, 3'b010, 1'b0, 1'b0, 0);
        run_instr("i_or",   7'b0010011, 3'b110, 1'b0, 1'b0, 0);
        run_instr("i_and",  7'b0010011, 3'b111, 1'b0, 1'b0, 0);
        run_instr("i_addf7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0);
        run_instr("jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 0);
        run_instr("ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 0);
        run_instr("ill_f3", 7'b0110011, 3'b001, 1'b0, 1'b0, 0);

        // lw aborted by reset while in MemRead: no RegWrite pulse, back to Fetch.
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 4);
        reset = 1'b1;
        e = model(4'd3, 7'b0000011, 3'b010, 1'b0, 1'b0);
        e.en = 5'b00000;
        sb.push_back(e);
        #1;
        pop_compare("abort_s3");
        @(posedge clk);
        e = model(4'd0, 7'b0000011, 3'b010, 1'b0, 1'b0);
        e.en = 5'b00000;
        sb.push_back(e);
        #1;
        pop_compare("abort_s0");
        reset = 1'b0;
        run_instr("after_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 0);

        // Final state must be Fetch with an empty scoreboard.
        #1;
        check_val("end.state", 32'(bus.state), 32'd0);
        check_val("end.sb",    32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multicycle RISC-V control unit; the driving end of the datapath ALU interface.
- Sequences fetch/decode/execute/writeback.
- Produces the 3-bit ALUControl code the ALU consumes and samples the ALU zero flag for branch resolution.
- Sits between the instruction register (op/funct fields) and the datapath muxes, register-file write enable, memory write enable and PC write enable.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (Fetch); held at default.
- STATE_W, 4, state register width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction opcode (IR[6:0])
- funct3  input  3  IR[14:12]
- funct7b5  input  1  IR[30]
- zero  input  1  ALU zero flag, same cycle as the ALU result
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address mux: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=MemData, 10=ALU result
- ALUSrcA  output  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1
- ALUSrcB  output  2  ALU B mux: 00=rs2, 01=ImmExt, 10=const 4
- ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  output  1  register-file write enable
- illegal_instr  output  1  one-cycle pulse in Decode on an unsupported opcode or funct3
- state  output  4  current state, for debug

Behaviour:
- Moore FSM plus combinational ALU decoder.
- Only the state register is sequential; all outputs decode from state, op, funct3, funct7b5 and zero.
- Reset:
  - reset=1 at a clk edge forces state=Fetch(0), regardless of the current state (mid-instruction abort allowed).
  - While reset=1, all enables (PCWrite, MemWrite, IRWrite, RegWrite) = 0 and illegal_instr = 0.
  - Mux selects follow Fetch encoding but are don't-care.
- States and outputs (unlisted enables = 0, unlisted selects = 00):
  - Fetch(0): AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1 -> Decode.
  - Decode(1): ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precompute). Next state by op:
    - 0000011 (lw) or 0100011 (sw) -> MemAdr
    - 0110011 -> ExecuteR
    - 0010011 -> ExecuteI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - other -> Fetch, illegal_instr=1
  - MemAdr(2): ALUSrcA=10, ALUSrcB=01, add -> MemRead if op=lw, else MemWrite.
  - MemRead(3): ResultSrc=00, AdrSrc=1 -> MemWB.
  - MemWB(4): ResultSrc=01, RegWrite=1 -> Fetch.
  - MemWrite(5): ResultSrc=00, AdrSrc=1, MemWrite=1 -> Fetch.
  - ExecuteR(6): ALUSrcA=10, ALUSrcB=00, ALUOp=funct -> ALUWB.
  - ExecuteI(7): ALUSrcA=10, ALUSrcB=01, ALUOp=funct -> ALUWB.
  - ALUWB(8): ResultSrc=00, RegWrite=1 -> Fetch.
  - JAL(9): ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
  - BEQ(10): ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=zero -> Fetch.
  - Encodings 11-15: unreachable; next state = Fetch, all enables 0.
- ALU decode:
  - ALUOp=add -> 000.
  - ALUOp=sub -> 001.
  - ALUOp=funct:
    - funct3=000 -> 001 if op[5]&funct7b5 (R-type sub), else 000.
    - funct3=010 -> 101.
    - funct3=110 -> 011.
    - funct3=111 -> 010.
    - Other funct3 -> 000; illegal_instr asserted in Decode for op 0110011/0010011 with an unsupported funct3.
- ImmSrc is combinational from op, valid in every state:
  - lw / I-type: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - other: 00
- Latency in cycles:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
  - illegal opcode: 2
- PCWrite in BEQ depends combinationally on zero in the same cycle; no registering.

Test Plan:
- reset held 2 cycles, released, op=0110011 funct3=000 funct7b5=1 -> states 0,1,6,8,0; ALUControl=001 in state 6; RegWrite=1 only in state 8.
- op=0000011 (lw) -> states 0,1,2,3,4,0; ImmSrc=00; AdrSrc=1 in state 3; ResultSrc=01 and RegWrite=1 in state 4; MemWrite never 1.
- op=0100011 (sw) -> states 0,1,2,5,0; ImmSrc=01; MemWrite=1 only in state 5.
- op=1100011, zero=1 then repeated with zero=0 -> states 0,1,10,0; ALUControl=001 in state 10; PCWrite=1 in state 10 only when zero=1.
- op=0010011 with funct3=010, then 110, then 111 -> ALUControl 101, 011, 010 in state 7; op=1101111 -> states 0,1,9,8,0 with PCWrite=1 in state 9.
- op=1111111 -> illegal_instr=1 in state 1, next state 0; reset asserted while in state 3 -> next state 0, no RegWrite pulse.
